lc3_seq_ctrl: RTL and testbench

- Multicycle sequencer for the LC3 core.
- Drives the stage enables (fetch, decode, execute, writeback, memory access, PC update) and runs the instruction-memory and data-memory complete handshakes.
- Sits beside fetch/decode in the LC3 top level. Consumes the opcode latched by decode; produces every stage enable.
- One instruction in flight at a time; no overlap between instructions.

---
 rtl/lc3_pkg.sv | 48 ++++
 rtl/lc3_wait_timer.sv | 36 +++
 rtl/lc3_seq_ctrl.sv | 175 +++++++++++++++++
 tb/tb_lc3_seq_ctrl.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// Shared LC3 sequencer definitions: opcodes, FSM states, memory-state and error codes.
package lc3_pkg;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_RSV  = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  typedef enum logic [3:0] {
    StReset,
    StFetch,
    StDecode,
    StExecute,
    StMemInd,
    StMem,
    StWb,
    StUpdPc,
    StHalt,
    StError
  } state_e;

  localparam logic [1:0] MEM_ST_READ  = 2'd0;
  localparam logic [1:0] MEM_ST_WRITE = 2'd1;
  localparam logic [1:0] MEM_ST_IND   = 2'd2;
  localparam logic [1:0] MEM_ST_IDLE  = 2'd3;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  // States that wait on a memory complete and are guarded by the wait timer.
  function automatic logic is_wait_state(input state_e s);
    return (s == StFetch) || (s == StMemInd) || (s == StMem);
  endfunction

endpackage

// File: rtl/lc3_wait_timer.sv
// Memory wait counter: cleared on entry to a wait state, counts while waiting,
// flags timeout once the count reaches MEM_TIMEOUT.
module lc3_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic timeout
);

  logic [CNT_W-1:0] count_q, count_d;

  assign timeout = (count_q == CNT_W'(MEM_TIMEOUT));

  // Saturate at the timeout value so a stalled count can never wrap back to zero.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (run && !timeout) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/lc3_seq_ctrl.sv
// LC3 multicycle sequencer: one instruction in flight, drives every stage enable
// and the instruction/data memory complete handshakes.
module lc3_seq_ctrl
  import lc3_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic       instr_mem_complete,
  input  logic       data_mem_complete,
  output logic       enable_fetch,
  output logic       instr_mem_rd,
  output logic       enable_decode,
  output logic       enable_execute,
  output logic       enable_writeback,
  output logic       enable_updatepc,
  output logic [1:0] mem_state,
  output logic       data_mem_en,
  output logic       data_mem_rd,
  output logic       halted,
  output logic [1:0] error,
  output logic [3:0] state
);

  state_e     state_q, state_d;
  logic       is_write_q, is_write_d;
  logic [1:0] err_q, err_d;
  logic       first_q;
  logic       from_ind_q;
  logic       timeout;
  logic       timer_clear;
  logic       timer_run;

  assign timer_clear = is_wait_state(state_d) && (state_d != state_q);
  assign timer_run   = is_wait_state(state_q);

  lc3_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .run    (timer_run),
    .timeout(timeout)
  );

  // first_q marks the first cycle of any state, where a stale complete is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StReset;
      is_write_q <= 1'b0;
      err_q      <= ERR_NONE;
      first_q    <= 1'b1;
      from_ind_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_write_q <= is_write_d;
      err_q      <= err_d;
      first_q    <= (state_d != state_q);
      from_ind_q <= (state_q == StMemInd) && (state_d == StMem);
    end
  end

  always_comb begin
    state_d    = state_q;
    is_write_d = is_write_q;
    err_d      = err_q;
    case (state_q)
      StReset:  state_d = StFetch;
      StFetch: begin
        if (instr_mem_complete && !first_q) begin
          state_d = StDecode;
        end else if (timeout) begin
          state_d = StError;
          err_d   = ERR_TIMEOUT;
        end
      end
      StDecode: state_d = StExecute;
      StExecute: begin
        case (opcode)
          OP_ADD, OP_AND, OP_NOT, OP_LEA, OP_JSR: state_d = StWb;
          OP_BR, OP_JMP:                          state_d = StUpdPc;
          OP_LD, OP_LDR: begin
            state_d    = StMem;
            is_write_d = 1'b0;
          end
          OP_ST, OP_STR: begin
            state_d    = StMem;
            is_write_d = 1'b1;
          end
          OP_LDI: begin
            state_d    = StMemInd;
            is_write_d = 1'b0;
          end
          OP_STI: begin
            state_d    = StMemInd;
            is_write_d = 1'b1;
          end
          OP_TRAP:        state_d = StHalt;
          OP_RTI, OP_RSV: begin
            state_d = StError;
            err_d   = ERR_ILLEGAL;
          end
          default: begin
            state_d = StError;
            err_d   = ERR_ILLEGAL;
          end
        endcase
      end
      StMemInd: begin
        if (data_mem_complete && !first_q) begin
          state_d = StMem;
        end else if (timeout) begin
          state_d = StError;
          err_d   = ERR_TIMEOUT;
        end
      end
      StMem: begin
        if (data_mem_complete && !first_q) begin
          state_d = is_write_q ? StUpdPc : StWb;
        end else if (timeout) begin
          state_d = StError;
          err_d   = ERR_TIMEOUT;
        end
      end
      StWb:            state_d = StUpdPc;
      StUpdPc:         state_d = StFetch;
      StHalt, StError: state_d = state_q;
      default:         state_d = StReset;
    endcase
  end

  always_comb begin
    enable_fetch     = 1'b0;
    instr_mem_rd     = 1'b0;
    enable_decode    = 1'b0;
    enable_execute   = 1'b0;
    enable_writeback = 1'b0;
    enable_updatepc  = 1'b0;
    mem_state        = MEM_ST_IDLE;
    data_mem_en      = 1'b0;
    data_mem_rd      = 1'b1;
    case (state_q)
      StFetch: begin
        enable_fetch = 1'b1;
        instr_mem_rd = 1'b1;
      end
      StDecode:  enable_decode  = 1'b1;
      StExecute: enable_execute = 1'b1;
      StMemInd: begin
        mem_state   = MEM_ST_IND;
        data_mem_en = 1'b1;
        data_mem_rd = 1'b1;
      end
      StMem: begin
        // The cycle right after the pointer read idles the bus between the two accesses.
        mem_state   = is_write_q ? MEM_ST_WRITE : MEM_ST_READ;
        data_mem_en = !from_ind_q;
        data_mem_rd = !is_write_q;
      end
      StWb:    enable_writeback = 1'b1;
      StUpdPc: enable_updatepc  = 1'b1;
      default: ;
    endcase
  end

  assign halted = (state_q == StHalt);
  assign error  = err_q;
  assign state  = 4'(state_q);

endmodule

// File: tb/tb_lc3_seq_ctrl.sv
// Self-checking bench for lc3_seq_ctrl: per-cycle expected traces built from the
// instruction-level timing rules, with random memory delays and input noise.
module tb_lc3_seq_ctrl;

  localparam logic [12:0] B_FE    = 13'h1800;
  localparam logic [12:0] B_DE    = 13'h0400;
  localparam logic [12:0] B_EX    = 13'h0200;
  localparam logic [12:0] B_WB    = 13'h0100;
  localparam logic [12:0] B_UP    = 13'h0080;
  localparam logic [12:0] B_EN    = 13'h0040;
  localparam logic [12:0] B_RD    = 13'h0020;
  localparam logic [12:0] B_HALT  = 13'h0004;
  localparam logic [12:0] MS_RD   = 13'h0000;
  localparam logic [12:0] MS_WR   = 13'h0008;
  localparam logic [12:0] MS_IND  = 13'h0010;
  localparam logic [12:0] MS_IDLE = 13'h0018;
  localparam logic [12:0] E_ILL   = 13'h0001;
  localparam logic [12:0] E_TMO   = 13'h0002;
  localparam logic [12:0] RST_VAL = 13'h0038;
  localparam int          TMO     = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] opcode = 4'h0;
  logic       instr_mem_complete = 1'b0;
  logic       data_mem_complete = 1'b0;
  logic       enable_fetch, instr_mem_rd, enable_decode, enable_execute;
  logic       enable_writeback, enable_updatepc, data_mem_en, data_mem_rd, halted;
  logic [1:0] mem_state, error;
  logic [3:0] state;
  logic [12:0] obs;

  always #5 clk = ~clk;

  lc3_seq_ctrl #(.MEM_TIMEOUT(64), .CNT_W(7)) dut (
    .clk               (clk),
    .rst               (rst),
    .opcode            (opcode),
    .instr_mem_complete(instr_mem_complete),
    .data_mem_complete (data_mem_complete),
    .enable_fetch      (enable_fetch),
    .instr_mem_rd      (instr_mem_rd),
    .enable_decode     (enable_decode),
    .enable_execute    (enable_execute),
    .enable_writeback  (enable_writeback),
    .enable_updatepc   (enable_updatepc),
    .mem_state         (mem_state),
    .data_mem_en       (data_mem_en),
    .data_mem_rd       (data_mem_rd),
    .halted            (halted),
    .error             (error),
    .state             (state)
  );

  assign obs = {enable_fetch, instr_mem_rd, enable_decode, enable_execute, enable_writeback,
                enable_updatepc, data_mem_en, data_mem_rd, mem_state, halted, error};

  // One expected cycle: outputs (val under mask) plus the inputs to drive during it.
  typedef struct {
    logic [12:0] val;
    logic [12:0] mask;
    logic        ic, dc, nic, ndc, ex;
    logic [3:0]  op;
  } entry_t;

  entry_t     exp_q[$];
  logic [3:0] cur_op = 4'h0;
  int         n_cmp = 0;
  int         n_bad = 0;

  // mem_state is only constrained in memory, PC-update and reset cycles; rd only while en.
  task automatic add(input logic [12:0] v, input bit ms_care, input bit ic_i, input bit dc_i,
                     input bit nic, input bit ndc, input bit ex);
    entry_t e;
    e.val  = v;
    e.mask = 13'h1FFF;
    if (!ms_care) e.mask &= ~MS_IDLE;
    if (!v[6]) e.mask &= ~B_RD;
    e.ic  = ic_i;
    e.dc  = dc_i;
    e.nic = nic;
    e.ndc = ndc;
    e.ex  = ex;
    e.op  = cur_op;
    exp_q.push_back(e);
  endtask

  // Complete/opcode noise only where the sequencer must ignore it.
  task automatic drive_cycle(input entry_t e);
    instr_mem_complete = e.ic | (e.nic & 1'($urandom));
    data_mem_complete  = e.dc | (e.ndc & 1'($urandom));
    opcode             = e.ex ? e.op : 4'($urandom);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    instr_mem_complete = 1'b0;
    data_mem_complete  = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    add(MS_IDLE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic add_fetch(input int cf, input bit done);
    for (int i = 1; i <= cf; i++) add(B_FE, 1'b0, done && (i == cf), 1'b0, i == 1, 1'b1, 1'b0);
  endtask

  task automatic add_dec_exe();
    add(B_DE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    add(B_EX, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic mem_access(input logic [12:0] v, input int c, input bit gap, input bit done);
    for (int i = 1; i <= c; i++)
      add((gap && i == 1) ? (v & ~B_EN) : v, 1'b1, 1'b0, done && (i == c), 1'b1, i == 1, 1'b0);
  endtask

  task automatic add_tail(input logic [12:0] v, input int n);
    for (int i = 0; i < n; i++) add(v, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic add_wb();
    add(B_WB, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic add_up();
    add(B_UP | MS_IDLE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic add_next_fetch();
    add(B_FE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  // Instruction-level model: phase list from the opcode class and the memory delays.
  task automatic build_instr(input logic [3:0] op, input int cf, input int c1, input int c2,
                             input int tail);
    cur_op = op;
    add_fetch(cf, 1'b1);
    add_dec_exe();
    case (op)
      4'h1, 4'h5, 4'h9, 4'hE, 4'h4: begin add_wb(); add_up(); end
      4'h0, 4'hC: add_up();
      4'h2, 4'h6: begin mem_access(B_EN | B_RD | MS_RD, c1, 1'b0, 1'b1); add_wb(); add_up(); end
      4'h3, 4'h7: begin mem_access(B_EN | MS_WR, c1, 1'b0, 1'b1); add_up(); end
      4'hA: begin
        mem_access(B_EN | B_RD | MS_IND, c1, 1'b0, 1'b1);
        mem_access(B_EN | B_RD | MS_RD, c2, 1'b1, 1'b1);
        add_wb();
        add_up();
      end
      4'hB: begin
        mem_access(B_EN | B_RD | MS_IND, c1, 1'b0, 1'b1);
        mem_access(B_EN | MS_WR, c2, 1'b1, 1'b1);
        add_up();
      end
      4'hF:    add_tail(B_HALT, tail);
      default: add_tail(E_ILL, tail);
    endcase
  endtask

  task automatic test_reset();
    int lim;
    #3;
    n_cmp++;
    if (obs !== RST_VAL) begin
      n_bad++;
      $display("FAIL reset_async: got %h want %h", obs, RST_VAL);
    end
    do_reset();
    add_fetch(4, 1'b0);
    foreach (exp_q[k]) begin
      n_cmp++;
      if ((obs & exp_q[k].mask) !== (exp_q[k].val & exp_q[k].mask)) begin
        n_bad++;
        $display("FAIL reset_pre cyc %0d: got %h want %h mask %h state %0d", k, obs,
                 exp_q[k].val, exp_q[k].mask, state);
      end
      drive_cycle(exp_q[k]);
    end
    #3 rst = 1'b1;
    #1;
    n_cmp++;
    if (obs !== RST_VAL) begin
      n_bad++;
      $display("FAIL reset_mid_fetch: got %h want %h", obs, RST_VAL);
    end
    do_reset();
    build_instr(4'h2, 2, 6, 0, 0);
    lim = 7;
    for (int k = 0; k < lim; k++) begin
      n_cmp++;
      if ((obs & exp_q[k].mask) !== (exp_q[k].val & exp_q[k].mask)) begin
        n_bad++;
        $display("FAIL reset_pre_mem cyc %0d: got %h want %h mask %h state %0d", k, obs,
                 exp_q[k].val, exp_q[k].mask, state);
      end
      drive_cycle(exp_q[k]);
    end
    #3 rst = 1'b1;
    #1;
    n_cmp++;
    if (obs !== RST_VAL) begin
      n_bad++;
      $display("FAIL reset_mid_mem: got %h want %h", obs, RST_VAL);
    end
    do_reset();
    build_instr(4'h1, 2, 0, 0, 0);
    add_next_fetch();
    foreach (exp_q[k]) begin
      n_cmp++;
      if ((obs & exp_q[k].mask) !== (exp_q[k].val & exp_q[k].mask)) begin
        n_bad++;
        $display("FAIL reset_release cyc %0d: got %h want %h mask %h state %0d", k, obs,
                 exp_q[k].val, exp_q[k].mask, state);
      end
      drive_cycle(exp_q[k]);
    end
  endtask

  task automatic test_alu();
    logic [15:0] add_instr;
    logic [3:0]  alu_ops[5];
    add_instr = 16'h1261;
    alu_ops   = '{4'h1, 4'h5, 4'h9, 4'hE, 4'h4};
    do_reset();
    build_instr(add_instr[15:12], 2, 0, 0, 0);
    for (int i = 0; i < 5; i++) build_instr(alu_ops[i], $urandom_range(2, 6), 0, 0, 0);
    build_instr(4'h0, 2, 0, 0, 0);
    build_instr(4'hC, $urandom_range(2, 6), 0, 0, 0);
    add_next_fetch();
    foreach (exp_q[k]) begin
      n_cmp++;
      if ((obs & exp_q[k].mask) !== (exp_q[k].val & exp_q[k].mask)) begin
        n_bad++;
        $display("FAIL alu_br cyc %0d: got %h want %h mask %h state %0d", k, obs,
                 exp_q[k].val, exp_q[k].mask, state);
      end
      drive_cycle(exp_q[k]);
    end
  endtask

  task automatic test_indirect();
    do_reset();
    build_instr(4'hA, 2, 4, 4, 0);
    build_instr(4'hA, 2, 2, 2, 0);
    build_instr(4'hB, 2, 4, 4, 0);
    build_instr(4'hB, $urandom_range(2, 5), $urandom_range(2, 5), $urandom_range(2, 5), 0);
    add_next_fetch();
    foreach (exp_q[k]) begin
      n_cmp++;
      if ((obs & exp_q[k].mask) !== (exp_q[k].val & exp_q[k].mask)) begin
        n_bad++;
        $display("FAIL indirect cyc %0d: got %h want %h mask %h state %0d", k, obs,
                 exp_q[k].val, exp_q[k].mask, state);
      end
      drive_cycle(exp_q[k]);
    end
  endtask

  task automatic test_load_store();
    logic [15:0] str_instr;
    str_instr = 16'h7042;
    do_reset();
    build_instr(str_instr[15:12], 2, 2, 0, 0);
    build_instr(4'h3, 2, $urandom_range(2, 6), 0, 0);
    build_instr(4'h2, 2, 2, 0, 0);
    build_instr(4'h6, $urandom_range(2, 6), $urandom_range(2, 6), 0, 0);
    add_next_fetch();
    foreach (exp_q[k]) begin
      n_cmp++;
      if ((obs & exp_q[k].mask) !== (exp_q[k].val & exp_q[k].mask)) begin
        n_bad++;
        $display("FAIL load_store cyc %0d: got %h want %h mask %h state %0d", k, obs,
                 exp_q[k].val, exp_q[k].mask, state);
      end
      drive_cycle(exp_q[k]);
    end
  endtask

  task automatic test_halt_error();
    logic [15:0] trap_instr;
    logic [3:0]  ops[3];
    trap_instr = 16'hF025;
    ops = '{4'hD, 4'h8, trap_instr[15:12]};
    for (int t = 0; t < 3; t++) begin
      do_reset();
      build_instr(ops[t], $urandom_range(2, 4), 0, 0, 10);
      foreach (exp_q[k]) begin
        n_cmp++;
        if ((obs & exp_q[k].mask) !== (exp_q[k].val & exp_q[k].mask)) begin
          n_bad++;
          $display("FAIL halt_error op %h cyc %0d: got %h want %h mask %h state %0d", ops[t],
                   k, obs, exp_q[k].val, exp_q[k].mask, state);
        end
        drive_cycle(exp_q[k]);
      end
    end
  endtask

  task automatic test_timeout();
    for (int t = 0; t < 4; t++) begin
      do_reset();
      case (t)
        0: begin add_fetch(TMO + 1, 1'b0); add_tail(E_TMO, 4); end
        1: begin build_instr(4'h1, TMO + 1, 0, 0, 0); add_next_fetch(); end
        2: begin
          cur_op = 4'h2;
          add_fetch(2, 1'b1);
          add_dec_exe();
          mem_access(B_EN | B_RD | MS_RD, TMO + 1, 1'b0, 1'b0);
          add_tail(E_TMO, 4);
        end
        default: begin build_instr(4'h3, 2, TMO + 1, 0, 0); add_next_fetch(); end
      endcase
      foreach (exp_q[k]) begin
        n_cmp++;
        if ((obs & exp_q[k].mask) !== (exp_q[k].val & exp_q[k].mask)) begin
          n_bad++;
          $display("FAIL timeout case %0d cyc %0d: got %h want %h mask %h state %0d", t, k,
                   obs, exp_q[k].val, exp_q[k].mask, state);
        end
        drive_cycle(exp_q[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] op;
    do_reset();
    for (int i = 0; i < 30; i++) begin
      do op = 4'($urandom); while (op == 4'h8 || op == 4'hD || op == 4'hF);
      build_instr(op, $urandom_range(2, 6), $urandom_range(2, 6), $urandom_range(2, 6), 0);
    end
    build_instr(4'hF, 2, 0, 0, 4);
    foreach (exp_q[k]) begin
      n_cmp++;
      if ((obs & exp_q[k].mask) !== (exp_q[k].val & exp_q[k].mask)) begin
        n_bad++;
        $display("FAIL back_to_back cyc %0d: got %h want %h mask %h state %0d", k, obs,
                 exp_q[k].val, exp_q[k].mask, state);
      end
      drive_cycle(exp_q[k]);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_indirect();
    test_load_store();
    test_halt_error();
    test_timeout();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
